// File: rtl/arp_cache_table.sv
// Multi-entry ARP cache: learns IP->MAC bindings, ages them out, answers lookups
// and asks the TX path for an ARP request when a lookup misses.
module arp_cache_table #(
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned TICK_DIV    = 125000000,
    parameter int unsigned AGE_LIMIT   = 300,
    parameter int unsigned REQ_TIMEOUT = 1000000
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           upd_valid,
    input  logic [31:0]                    upd_ip,
    input  logic [47:0]                    upd_mac,
    input  logic                           flush,
    input  logic                           lkp_valid,
    output logic                           lkp_ready,
    input  logic [31:0]                    lkp_ip,
    output logic                           rsp_valid,
    output logic                           rsp_hit,
    output logic [47:0]                    rsp_mac,
    output logic                           arp_req_start,
    output logic [31:0]                    arp_req_ip,
    input  logic                           arp_req_done,
    output logic [$clog2(ENTRIES+1)-1:0]   entry_count
);
    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned CW = $clog2(ENTRIES + 1);
    localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_REQ, S_WAIT} state_t;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [31:0]        ip_q  [ENTRIES];
    logic [47:0]        mac_q [ENTRIES];
    logic [AW-1:0]      age_q [ENTRIES];
    logic [AW-1:0]      age_d [ENTRIES];
    logic [PW-1:0]      presc_q;
    logic [CW-1:0]      count_d;

    logic               tick_c, upd_en_c;
    logic               match_any, free_any;
    logic [IW-1:0]      match_idx, free_idx, old_idx, sel_idx;
    logic [AW-1:0]      old_age;
    logic               lkp_hit_c;
    logic [47:0]        lkp_mac_c;

    state_t             state_q, state_d;
    logic [31:0]        pend_ip_q, pend_ip_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               lkp_ready_d, rsp_valid_d, rsp_hit_d, arp_req_start_d;
    logic [47:0]        rsp_mac_d;
    logic [31:0]        arp_req_ip_d;

    assign tick_c   = (presc_q == PW'(TICK_DIV - 1));
    assign upd_en_c = upd_valid && (upd_ip != 32'd0) && !flush;

    // Slot choice for an update: existing binding, else first free, else oldest
    always_comb begin : slot_select
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        old_idx   = '0;
        old_age   = age_q[0];
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_q[i] == upd_ip)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        for (int i = 1; i < int'(ENTRIES); i++) begin
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = IW'(i);
            end
        end
        sel_idx = match_any ? match_idx : (free_any ? free_idx : old_idx);
    end

    // Next valid/age state: flush > update > aging
    always_comb begin : table_next
        valid_d = valid_q;
        age_d   = age_q;
        count_d = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (upd_en_c && (sel_idx == IW'(i))) begin
                valid_d[i] = 1'b1;
                age_d[i]   = '0;
            end else if (tick_c && valid_q[i]) begin
                age_d[i] = age_q[i] + AW'(1);
                if (age_q[i] == AW'(AGE_LIMIT - 1)) begin
                    valid_d[i] = 1'b0;
                end
            end
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge aclk) begin : table_reg
        if (!aresetn) begin
            valid_q     <= '0;
            presc_q     <= '0;
            entry_count <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            age_q       <= age_d;
            presc_q     <= tick_c ? '0 : presc_q + PW'(1);
            entry_count <= count_d;
            if (upd_en_c) begin
                ip_q[sel_idx]  <= upd_ip;
                mac_q[sel_idx] <= upd_mac;
            end
        end
    end

    // Lookup compares against the table as it stands before the accepting edge
    always_comb begin : lkp_match
        lkp_hit_c = 1'b0;
        lkp_mac_c = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[i] && (ip_q[i] == lkp_ip)) begin
                lkp_hit_c = 1'b1;
                lkp_mac_c = lkp_mac_c | mac_q[i];
            end
        end
    end

    always_comb begin : fsm_next
        state_d         = state_q;
        pend_ip_d       = pend_ip_q;
        tmo_d           = tmo_q;
        rsp_valid_d     = 1'b0;
        rsp_hit_d       = rsp_hit;
        rsp_mac_d       = rsp_mac;
        arp_req_start_d = 1'b0;
        arp_req_ip_d    = arp_req_ip;
        case (state_q)
            S_IDLE: begin
                if (lkp_valid && lkp_ready) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = lkp_hit_c;
                    rsp_mac_d   = lkp_mac_c;
                    pend_ip_d   = lkp_ip;
                end
            end
            S_RESP: begin
                if (rsp_hit) begin
                    state_d = S_IDLE;
                end else begin
                    state_d         = S_REQ;
                    arp_req_start_d = 1'b1;
                    arp_req_ip_d    = pend_ip_q;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                if (arp_req_done || (upd_valid && (upd_ip == arp_req_ip)) ||
                    (tmo_q == TW'(REQ_TIMEOUT - 1))) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        lkp_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge aclk) begin : fsm_reg
        if (!aresetn) begin
            state_q       <= S_IDLE;
            pend_ip_q     <= '0;
            tmo_q         <= '0;
            lkp_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_mac       <= '0;
            arp_req_start <= 1'b0;
            arp_req_ip    <= '0;
        end else begin
            state_q       <= state_d;
            pend_ip_q     <= pend_ip_d;
            tmo_q         <= tmo_d;
            lkp_ready     <= lkp_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_hit       <= rsp_hit_d;
            rsp_mac       <= rsp_mac_d;
            arp_req_start <= arp_req_start_d;
            arp_req_ip    <= arp_req_ip_d;
        end
    end

endmodule

// File: tb/tb_arp_cache_table.sv
// Directed bench for arp_cache_table: main instance (TICK_DIV=8) plus a fast-aging
// instance (TICK_DIV=4, AGE_LIMIT=3) sharing the same stimulus.
module tb_arp_cache_table;
    logic        clk = 1'b0;
    logic        aresetn;
    logic        upd_valid;
    logic [31:0] upd_ip;
    logic [47:0] upd_mac;
    logic        flush;
    logic        lkp_valid;
    logic [31:0] lkp_ip;
    logic        arp_req_done;

    logic        lkp_ready, rsp_valid, rsp_hit, arp_req_start;
    logic [47:0] rsp_mac;
    logic [31:0] arp_req_ip;
    logic [2:0]  entry_count;

    logic        lkp_ready_ag, rsp_valid_ag, rsp_hit_ag, arp_req_start_ag;
    logic [47:0] rsp_mac_ag;
    logic [31:0] arp_req_ip_ag;
    logic [2:0]  entry_count_ag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arp_cache_table #(.ENTRIES(4), .TICK_DIV(8), .AGE_LIMIT(100), .REQ_TIMEOUT(16)) dut (
        .aclk(clk), .aresetn(aresetn), .upd_valid(upd_valid), .upd_ip(upd_ip),
        .upd_mac(upd_mac), .flush(flush), .lkp_valid(lkp_valid), .lkp_ready(lkp_ready),
        .lkp_ip(lkp_ip), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_mac(rsp_mac),
        .arp_req_start(arp_req_start), .arp_req_ip(arp_req_ip),
        .arp_req_done(arp_req_done), .entry_count(entry_count)
    );

    arp_cache_table #(.ENTRIES(4), .TICK_DIV(4), .AGE_LIMIT(3), .REQ_TIMEOUT(16)) dut_ag (
        .aclk(clk), .aresetn(aresetn), .upd_valid(upd_valid), .upd_ip(upd_ip),
        .upd_mac(upd_mac), .flush(flush), .lkp_valid(lkp_valid), .lkp_ready(lkp_ready_ag),
        .lkp_ip(lkp_ip), .rsp_valid(rsp_valid_ag), .rsp_hit(rsp_hit_ag), .rsp_mac(rsp_mac_ag),
        .arp_req_start(arp_req_start_ag), .arp_req_ip(arp_req_ip_ag),
        .arp_req_done(arp_req_done), .entry_count(entry_count_ag)
    );

    // Returns one cycle before the first non-reset edge (E1)
    task automatic do_reset();
        aresetn = 1'b0; upd_valid = 1'b0; upd_ip = '0; upd_mac = '0; flush = 1'b0;
        lkp_valid = 1'b0; lkp_ip = '0; arp_req_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        upd_valid = 1'b1; upd_ip = ip; upd_mac = mac;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic pulse_done();
        arp_req_done = 1'b1;
        @(posedge clk);
        #1 arp_req_done = 1'b0;
    endtask

    // Returns just after the accepting edge, sampling the RESP cycle
    task automatic lookup(input logic [31:0] ip, output logic v, output logic h,
                          output logic [47:0] m, output int waited);
        waited = 0;
        while (!lkp_ready && waited < 200) begin
            @(posedge clk); #1 waited++;
        end
        if (!lkp_ready) begin
            checks++; errors++;
            $display("FAIL lkp_ready_wait: lkp_ready=%0b after %0d cycles, need 1", lkp_ready, waited);
        end
        lkp_valid = 1'b1; lkp_ip = ip;
        @(posedge clk);
        #1 lkp_valid = 1'b0;
        v = rsp_valid; h = rsp_hit; m = rsp_mac;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; upd_valid = 1'b0; flush = 1'b0; lkp_valid = 1'b0; arp_req_done = 1'b0;
        upd_ip = '0; upd_mac = '0; lkp_ip = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (lkp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b need 0", lkp_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b need 0", rsp_valid); end
        checks++; if (entry_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d need 0", entry_count); end
        checks++; if (arp_req_ip !== 32'd0) begin errors++; $display("FAIL reset_req_ip: got %h need 0", arp_req_ip); end
        aresetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (lkp_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b need 1", lkp_ready); end
    endtask

    task automatic test_basic_hit();
        logic v, h; logic [47:0] m; int w; bit seen;
        do_reset();
        learn(32'hC0A8010A, 48'h001122334455);
        checks++; if (entry_count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d need 1", entry_count); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_rsp: got %0b need 0", rsp_valid); end
        lookup(32'hC0A8010A, v, h, m, w);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid: got %0b need 1", v); end
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL basic_hit: got %0b need 1", h); end
        checks++; if (m !== 48'h001122334455) begin errors++; $display("FAIL basic_mac: got %h need 001122334455", m); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_one_cycle: got %0b need 0", rsp_valid); end
        seen = 1'b0;
        repeat (4) begin
            if (arp_req_start) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL basic_no_req: got %0b need 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic v, h; logic [47:0] m; int w;
        lookup(32'hC0A8010A, v, h, m, w);
        lookup(32'hC0A8010A, v, h, m, w);
        checks++; if (w !== 1) begin errors++; $display("FAIL b2b_gap: waited %0d need 1", w); end
        checks++; if (h !== 1'b1 || v !== 1'b1) begin errors++; $display("FAIL b2b_hit: got v=%0b h=%0b need 1/1", v, h); end
    endtask

    task automatic test_eviction();
        logic v, h; logic [47:0] m; int w;
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            learn(32'hC0A80100 | 32'(n), 48'h020000000000 | 48'(n));
            if (n < 5) repeat (7) @(posedge clk);
        end
        #1;
        checks++; if (entry_count !== 3'd4) begin errors++; $display("FAIL evict_count: got %0d need 4", entry_count); end
        for (int n = 2; n <= 5; n++) begin
            lookup(32'hC0A80100 | 32'(n), v, h, m, w);
            checks++;
            if (h !== 1'b1 || m !== (48'h020000000000 | 48'(n))) begin
                errors++; $display("FAIL evict_hit_%0d: got h=%0b mac=%h need 1 mac=%h", n, h, m, 48'h020000000000 | 48'(n));
            end
        end
        lookup(32'hC0A80101, v, h, m, w);
        checks++; if (h !== 1'b0 || v !== 1'b1) begin errors++; $display("FAIL evict_miss_1: got v=%0b h=%0b need 1/0", v, h); end
        repeat (2) @(posedge clk);
        pulse_done();
        checks++; if (entry_count !== 3'd4) begin errors++; $display("FAIL evict_count_end: got %0d need 4", entry_count); end
    endtask

    task automatic test_miss_req();
        logic v, h; logic [47:0] m; int w; int n; bit extra;
        do_reset();
        lookup(32'hC0A80163, v, h, m, w);
        checks++; if (v !== 1'b1 || h !== 1'b0 || m !== 48'd0) begin
            errors++; $display("FAIL miss_rsp: got v=%0b h=%0b mac=%h need 1/0/0", v, h, m); end
        @(posedge clk); #1;
        checks++; if (arp_req_start !== 1'b1) begin errors++; $display("FAIL miss_start: got %0b need 1", arp_req_start); end
        checks++; if (arp_req_ip !== 32'hC0A80163) begin errors++; $display("FAIL miss_req_ip: got %h need C0A80163", arp_req_ip); end
        @(posedge clk); #1;
        checks++; if (arp_req_start !== 1'b0) begin errors++; $display("FAIL miss_start_one_cycle: got %0b need 0", arp_req_start); end
        repeat (5) @(posedge clk); #1;
        checks++; if (lkp_ready !== 1'b0) begin errors++; $display("FAIL miss_wait_ready: got %0b need 0", lkp_ready); end
        pulse_done();
        checks++; if (lkp_ready !== 1'b1) begin errors++; $display("FAIL miss_done_ready: got %0b need 1", lkp_ready); end
        // Second request left to time out
        lookup(32'hC0A80163, v, h, m, w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n = 0; extra = 1'b0;
        while (!lkp_ready && n < 100) begin
            @(posedge clk); #1 n++;
            if (arp_req_start) extra = 1'b1;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL miss_timeout: %0d cycles need 16", n); end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL miss_extra_start: got %0b need 0", extra); end
    endtask

    task automatic test_aging();
        do_reset();
        learn(32'hC0A80120, 48'hAABBCCDDEEFF);          // E1
        repeat (10) @(posedge clk); #1;                 // after E11
        checks++; if (entry_count_ag !== 3'd1) begin errors++; $display("FAIL age_before: got %0d need 1", entry_count_ag); end
        @(posedge clk); #1;                             // after E12
        checks++; if (entry_count_ag !== 3'd0) begin errors++; $display("FAIL age_expire: got %0d need 0", entry_count_ag); end
        learn(32'hC0A80120, 48'hAABBCCDDEEFF);          // E13
        repeat (10) @(posedge clk);
        learn(32'hC0A80120, 48'hAABBCCDDEEFF);          // E24, tick edge
        checks++; if (entry_count_ag !== 3'd1) begin errors++; $display("FAIL age_refresh_tick: got %0d need 1", entry_count_ag); end
        repeat (11) @(posedge clk); #1;                 // after E35
        checks++; if (entry_count_ag !== 3'd1) begin errors++; $display("FAIL age_refresh_hold: got %0d need 1", entry_count_ag); end
        @(posedge clk); #1;                             // after E36
        checks++; if (entry_count_ag !== 3'd0) begin errors++; $display("FAIL age_refresh_expire: got %0d need 0", entry_count_ag); end
    endtask

    task automatic test_flush_update();
        logic v, h; logic [47:0] m; int w;
        do_reset();
        flush = 1'b1;
        learn(32'hC0A80130, 48'h111111111111);
        flush = 1'b0;
        checks++; if (entry_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d need 0", entry_count); end
        lookup(32'hC0A80130, v, h, m, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL flush_lookup: got hit=%0b need 0", h); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        learn(32'hC0A80130, 48'h222222222222);
        checks++; if (lkp_ready !== 1'b1) begin errors++; $display("FAIL upd_exit_wait: got %0b need 1", lkp_ready); end
        learn(32'hC0A80130, 48'h333333333333);
        checks++; if (entry_count !== 3'd1) begin errors++; $display("FAIL upd_same_count: got %0d need 1", entry_count); end
        lookup(32'hC0A80130, v, h, m, w);
        checks++; if (h !== 1'b1 || m !== 48'h333333333333) begin
            errors++; $display("FAIL upd_new_mac: got h=%0b mac=%h need 1 mac=333333333333", h, m); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        logic v, h; logic [47:0] m; int w; bit seen;
        do_reset();
        learn(32'hC0A80140, 48'h444444444444);
        lookup(32'hC0A80141, v, h, m, w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        aresetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lkp_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_mac !== 48'd0 ||
            arp_req_start !== 1'b0 || arp_req_ip !== 32'd0 || entry_count !== 3'd0) begin
            errors++;
            $display("FAIL wait_reset_outputs: rdy=%0b rv=%0b hit=%0b mac=%h st=%0b ip=%h cnt=%0d need all 0",
                     lkp_ready, rsp_valid, rsp_hit, rsp_mac, arp_req_start, arp_req_ip, entry_count);
        end
        aresetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (lkp_ready !== 1'b1) begin errors++; $display("FAIL wait_reset_ready: got %0b need 1", lkp_ready); end
        seen = 1'b0;
        repeat (5) begin
            if (arp_req_start) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wait_reset_start: got %0b need 0", seen); end
        lookup(32'hC0A80140, v, h, m, w);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL wait_reset_table: got hit=%0b need 0", h); end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_back_to_back();
        test_eviction();
        test_miss_req();
        test_aging();
        test_flush_update();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/arp_cache_table.md
Name: arp_cache_table

Overview:
Multi-entry ARP cache, parametrised successor to the single-entry ARP cache in the UDP/ARP Ethernet core. Learns IP->MAC bindings from validated ARP frames (RX side) and answers MAC lookups for the TX path. On a miss it requests an ARP request frame from the TX path. Entries age out; when the table is full the oldest entry is replaced.

Parameters:
ENTRIES, 4, number of cache slots (>=2).
TICK_DIV, 125000000, aclk cycles per age tick.
AGE_LIMIT, 300, age ticks after which an entry is invalidated.
REQ_TIMEOUT, 1000000, aclk cycles to wait for arp_req_done before abandoning a request.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset, synchronous, active-low.
upd_valid  in  1  one-cycle strobe: learn or refresh a binding (ARP done and CRC valid).
upd_ip  in  32  sender IP of the binding.
upd_mac  in  48  sender MAC of the binding.
flush  in  1  one-cycle strobe: invalidate all entries.
lkp_valid  in  1  lookup request.
lkp_ready  out  1  lookup accepted when lkp_valid && lkp_ready.
lkp_ip  in  32  IP to resolve.
rsp_valid  out  1  one-cycle lookup result strobe.
rsp_hit  out  1  1 = binding found.
rsp_mac  out  48  resolved MAC (0 on miss).
arp_req_start  out  1  one-cycle pulse: TX must send an ARP request for arp_req_ip.
arp_req_ip  out  32  target IP of the pending request.
arp_req_done  in  1  TX finished sending the request.
entry_count  out  $clog2(ENTRIES+1)  number of valid entries.

Behaviour:
- Reset (aresetn=0 at an aclk edge): all entries invalid, ages 0, prescaler 0, FSM IDLE; lkp_ready=0, rsp_valid=0, rsp_hit=0, rsp_mac=0, arp_req_start=0, arp_req_ip=0, entry_count=0. Reset mid-request abandons it with no pulse. lkp_ready rises in the first cycle after release.
- Each entry holds valid, ip[31:0], mac[47:0], and age with width $clog2(AGE_LIMIT+1).
- Update, applied at the edge where upd_valid=1, in priority order:
  - a valid entry with ip==upd_ip gets its mac overwritten and age set to 0;
  - else the lowest-index invalid slot is filled with age 0;
  - else the entry with the highest age is evicted (tie goes to the lowest index) and filled with age 0.
  - upd_ip==0 is ignored.
- Flush clears all valid bits. Flush beats an update in the same cycle; the update is dropped. Flush does not disturb the FSM.
- Aging:
  - The prescaler counts 0..TICK_DIV-1; the wrap cycle is a tick.
  - On a tick, every valid age increments. An entry whose incremented age equals AGE_LIMIT becomes invalid.
  - If an update hits an entry in the tick cycle, the update wins (age=0, valid).
- entry_count is registered: it reflects the table as it stands after the edge.
- Lookup FSM:
  - IDLE: lkp_ready=1. On accept, lkp_ip is compared in parallel against the table state before that edge, and the result is registered. -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, with rsp_hit and rsp_mac. Hit -> IDLE. Miss -> REQ, latching arp_req_ip=lkp_ip.
  - REQ: arp_req_start=1 for exactly one cycle. -> WAIT.
  - WAIT: timeout counter runs. Exit to IDLE on arp_req_done, on an update with upd_ip==arp_req_ip, or when the counter reaches REQ_TIMEOUT-1.
  - Lookup latency: accept at cycle N gives rsp_valid at cycle N+1. Back-to-back hits sustain one lookup every 2 cycles.
- An update and a lookup of the same IP in the same cycle: the lookup sees the pre-update table and misses. The FSM then leaves WAIT on the next matching update or on arp_req_done.
- All outputs are registered. No combinational path runs from inputs to outputs.

Test Plan:
- Reset, then update ip=C0A8010A mac=001122334455, then lookup C0A8010A -> rsp_valid 1 cycle after accept, rsp_hit=1, rsp_mac=001122334455, entry_count=1, arp_req_start never asserted.
- ENTRIES=4: learn IPs .1, .2, .3, .4 with age ticks between them (TICK_DIV=8), then learn .5 -> .1 is evicted; lookup .1 misses, lookups .2 to .5 hit; entry_count stays 4.
- Lookup of unknown IP C0A80163 -> rsp_hit=0, rsp_mac=0, one arp_req_start pulse with arp_req_ip=C0A80163, lkp_ready=0 until arp_req_done; repeat without done -> FSM returns to IDLE after REQ_TIMEOUT cycles.
- TICK_DIV=4, AGE_LIMIT=3: learn one entry, no refresh -> invalid after 12 cycles, entry_count 1->0. Refresh in the tick cycle -> entry stays valid with age 0.
- Flush and update in the same cycle -> entry_count=0 and a lookup misses. Update of an existing IP with a new MAC -> entry_count unchanged and the lookup returns the new MAC.
- Assert aresetn=0 during WAIT -> all outputs 0 the next cycle, table empty, no arp_req_start after release, lkp_ready=1 one cycle after release.
